uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_rx.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared FSM encoding, frame constants and baud divisor helper for
//            the UART receiver. Optional macro: UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int OVS_DEFAULT = 16;
    localparam int DATA_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    // Truncating divide; clamped to 1 so a too-fast baud still yields a tick
    function automatic int calc_divisor(input int clk_hz, input int baud, input int ovs);
        int div;
        div = clk_hz / (baud * ovs);
        if (div < 1) div = 1;
        return div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Free-running oversample tick generator, one-cycle tick on wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int OVS    = OVS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = calc_divisor(CLK_HZ, BAUD, OVS);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling 8N1 UART receiver with consumer gating and framing
//            error pulse. Macro UART_RX_PARITY_EN adds an even parity bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int OVS    = OVS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 want,
    output logic [DATA_BITS-1:0] rhr_data,
    output logic [7:0]           rx_data_ready,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int BW = $clog2(DATA_BITS);

    logic [1:0] rst_pipe;
    logic       rst_n;
    logic [1:0] rx_pipe;
    logic       rx_s;
    logic       tick;

    rx_state_t            state, state_nx;
    logic [TW-1:0]        tcnt, tcnt_nx;
    logic [BW-1:0]        bcnt, bcnt_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [DATA_BITS-1:0] rhr_nx;
    logic [7:0]           cnt_nx;
    logic                 valid_nx, ferr_nx;
    logic                 stop_ok;

    // Asynchronous assert, synchronous release of the internal reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_pipe <= 2'b11;
        else        rx_pipe <= {rx_pipe[0], rx};
    end
    assign rx_s = rx_pipe[1];

    uart_baud_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OVS    (OVS)
    ) u_baud_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic perr, perr_nx;
    assign stop_ok = rx_s && !perr;
`else
    assign stop_ok = rx_s;
`endif

    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        bcnt_nx  = bcnt;
        shift_nx = shift;
        rhr_nx   = rhr_data;
        cnt_nx   = rx_data_ready;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_nx  = perr;
`endif
        unique case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx = ST_START;
                    tcnt_nx  = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt == TW'(OVS / 2 - 1)) begin
                        tcnt_nx  = '0;
                        bcnt_nx  = '0;
                        state_nx = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
                        perr_nx  = 1'b0;
`endif
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tcnt == TW'(OVS - 1)) begin
                        tcnt_nx  = '0;
                        shift_nx = {rx_s, shift[DATA_BITS-1:1]};
                        bcnt_nx  = bcnt + BW'(1);
                        if (bcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = ST_PARITY;
`else
                            state_nx = ST_STOP;
`endif
                        end
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (tcnt == TW'(OVS - 1)) begin
                        tcnt_nx  = '0;
                        perr_nx  = rx_s ^ (^shift);
                        state_nx = ST_STOP;
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (tcnt == TW'(OVS - 1)) begin
                        tcnt_nx = '0;
                        if (stop_ok) begin
                            state_nx = ST_IDLE;
                            if (want) begin
                                rhr_nx   = shift;
                                cnt_nx   = rx_data_ready + 8'd1;
                                valid_nx = 1'b1;
                            end
                        end else begin
                            ferr_nx  = 1'b1;
                            state_nx = ST_WAIT_IDLE;
                        end
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Line must stay high for a whole bit before hunting again
                if (!rx_s) begin
                    tcnt_nx = '0;
                end else if (tick) begin
                    if (tcnt == TW'(OVS - 1)) begin
                        tcnt_nx  = '0;
                        state_nx = ST_IDLE;
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tcnt          <= '0;
            bcnt          <= '0;
            shift         <= '0;
            rhr_data      <= '0;
            rx_data_ready <= '0;
            rx_valid      <= 1'b0;
            frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr          <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            tcnt          <= tcnt_nx;
            bcnt          <= bcnt_nx;
            shift         <= shift_nx;
            rhr_data      <= rhr_nx;
            rx_data_ready <= cnt_nx;
            rx_valid      <= valid_nx;
            frame_err     <= ferr_nx;
`ifdef UART_RX_PARITY_EN
            perr          <= perr_nx;
`endif
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Randomized self-checking bench for uart_rx against a frame-level
//            model. Honours UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

    // Scaled line rate (divisor 2, OVS 8) keeps 256+ frames inside the cycle budget
    localparam int OVS    = 8;
    localparam int BAUD   = 115200;
    localparam int CLK_HZ = BAUD * OVS * 2;
    localparam int BIT    = (CLK_HZ / (BAUD * OVS)) * OVS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       want  = 1'b1;
    logic [7:0] rhr_data;
    logic [7:0] rx_data_ready;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  mdl_cnt   = 8'd0;
    logic [7:0]  mdl_rhr   = 8'd0;
    int          exp_valid = 0;
    int          exp_ferr  = 0;
    int          mon_valid = 0;
    int          mon_ferr  = 0;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OVS    (OVS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .want          (want),
        .rhr_data      (rhr_data),
        .rx_data_ready (rx_data_ready),
        .rx_valid      (rx_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid || frame_err)
            check_eq("valid_ferr_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
        if (rx_valid) begin
            mon_valid++;
            check_eq("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check_eq("rhr_data", {24'd0, rhr_data}, {24'd0, e[7:0]});
                check_eq("rx_data_ready", {24'd0, rx_data_ready}, {24'd0, e[15:8]});
            end
        end
        if (frame_err) mon_ferr++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        rx    = 1'b1;
        wait_clks(4);
        check_eq("rst_rhr_data", {24'd0, rhr_data}, 32'd0);
        check_eq("rst_count", {24'd0, rx_data_ready}, 32'd0);
        check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        mdl_cnt = 8'd0;
        mdl_rhr = 8'd0;
        exp_q.delete();
        reset = 1'b1;
        wait_clks(4);
    endtask

    // Drive one frame on the line; par_flip inverts the even parity bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT);
        end
        if (PAR_EN) begin
            rx = (^d) ^ par_flip;
            wait_clks(BIT);
        end
        rx = stop;
        wait_clks(BIT);
        rx = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] d, input logic stop, input logic par_flip);
        logic good;
        good = stop && !(PAR_EN && par_flip);
        if (good && want) begin
            mdl_cnt = mdl_cnt + 8'd1;
            mdl_rhr = d;
            exp_q.push_back({mdl_cnt, d});
            exp_valid++;
        end else if (!good) begin
            exp_ferr++;
        end
        send_frame(d, stop, par_flip);
        if (!good) wait_clks(2 * BIT);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_valid_cnt"}, mon_valid, exp_valid);
        check_eq({tag, "_ferr_cnt"}, mon_ferr, exp_ferr);
        check_eq({tag, "_count"}, {24'd0, rx_data_ready}, {24'd0, mdl_cnt});
        check_eq({tag, "_rhr"}, {24'd0, rhr_data}, {24'd0, mdl_rhr});
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        apply_reset();
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        want = 1'b1;
        xfer(8'hA5, 1'b1, 1'b0);
        wait_clks(BIT);
        check_state("a5");

        apply_reset();
        for (int i = 0; i < 256; i++) xfer(i[7:0], 1'b1, 1'b0);
        wait_clks(BIT);
        check_state("wrap");
        check_eq("wrap_count_zero", {24'd0, rx_data_ready}, 32'd0);

        xfer(8'h3C, 1'b0, 1'b0);
        check_state("bad_stop");
        xfer(8'h55, 1'b1, 1'b0);
        wait_clks(BIT);
        check_state("after_err");

        want = 1'b0;
        xfer(8'h11, 1'b1, 1'b0);
        want = 1'b1;
        xfer(8'h22, 1'b1, 1'b0);
        wait_clks(BIT);
        check_state("want");

        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        check_eq("glitch_busy_hi", {31'd0, busy}, 32'd1);
        wait_clks(BIT);
        check_state("glitch");

        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       stop, flip;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            flip = ($urandom_range(0, 7) == 0);
            want = ($urandom_range(0, 3) != 0);
            xfer(d, stop, flip);
            wait_clks($urandom_range(0, BIT));
        end
        want = 1'b1;
        wait_clks(BIT);
        check_state("random");

        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h77 >> i) & 8'h01;
            wait_clks(BIT);
        end
        rx = 1'b1;
        wait_clks(BIT / 2);
        apply_reset();
        wait_clks(2 * BIT);
        xfer(8'h99, 1'b1, 1'b0);
        wait_clks(BIT);
        check_state("mid_reset");
        check_eq("mid_reset_rhr_99", {24'd0, rhr_data}, 32'h99);

        if (PAR_EN) begin
            xfer(8'h01, 1'b1, 1'b1);
            check_state("parity");
            xfer(8'h5A, 1'b1, 1'b0);
            wait_clks(BIT);
            check_state("parity_ok");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
